// File: rtl/blit_q_pkg.sv
// Shared types and constants for the blitter command queue: sequencer states,
// job payload layout, status and control bit positions.
package blit_q_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STAT_W      = 16;
    localparam int unsigned STAT_OVF    = 15;
    localparam int unsigned STAT_IRQ    = 14;
    localparam int unsigned STAT_BUSY   = 13;
    localparam int unsigned STAT_IE     = 12;
    localparam int unsigned STAT_FILL_W = 5;

    localparam int unsigned CTL_IE      = 0;
    localparam int unsigned CTL_FLUSH   = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LDCNT  = 3'd1,
        LDCMD  = 3'd2,
        WSTART = 3'd3,
        RUN    = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] cnt;
        logic [DATA_W-1:0] cmd;
    } blit_job_t;

endpackage

// File: rtl/blit_q_fifo.sv
// Circular job buffer: DEPTH entries, wrapping pointers, fill counter, flush.
module blit_q_fifo
    import blit_q_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_flush,
    input  blit_job_t i_din,
    output blit_job_t o_head_c,
    output logic [AW:0] o_fill,
    output logic      o_full_c,
    output logic      o_empty_c
);

    localparam int unsigned FILL_W = AW + 1;

    blit_job_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_fill;
    logic           w_wr;
    logic           w_rd;

    // Full/empty use the pre-cycle fill, so a push while full is dropped even alongside a pop.
    assign o_full_c  = (r_fill == FILL_W'(DEPTH));
    assign o_empty_c = (r_fill == '0);
    assign w_wr      = i_push && !o_full_c && !i_flush;
    assign w_rd      = i_pop && !o_empty_c && !i_flush;
    assign o_head_c  = r_mem[r_rd_ptr];
    assign o_fill    = r_fill;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

// File: rtl/blit_cmd_queue.sv
// Blit job queue and sequencer: buffers GPU jobs, loads each into the blitter
// outer loop, waits for completion, and interrupts when the queue drains.
module blit_cmd_queue
    import blit_q_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] gpu_din,
    input  logic        q_cnt_wr,
    input  logic        q_cmd_wr,
    input  logic        q_ctl_wr,
    input  logic        q_stat_rd,
    input  logic        active,
    input  logic        stopped,
    output logic [31:0] blit_dout,
    output logic        countld,
    output logic        cmdld,
    output logic [15:0] q_stat_dout,
    output logic        q_stat_oe,
    output logic        q_irq,
    output logic        q_full
);

    localparam int unsigned FILL_W = AW + 1;

    seq_state_t          r_state;
    logic [DATA_W-1:0]   r_stage_cnt;
    logic [DATA_W-1:0]   r_blit_dout;
    logic                r_countld;
    logic                r_cmdld;
    logic                r_irq;
    logic                r_ovf;
    logic                r_irq_en;

    blit_job_t           w_job;
    blit_job_t           w_head;
    logic [AW:0]         w_fill;
    logic                w_full;
    logic                w_empty;
    logic                w_flush;
    logic                w_push;
    logic                w_pop;
    logic                w_irq_set;
    logic                w_ovf_set;
    logic [STAT_W-1:0]   w_stat;

    assign w_job     = '{cnt: r_stage_cnt, cmd: gpu_din};
    assign w_flush   = q_ctl_wr && gpu_din[CTL_FLUSH];
    assign w_push    = q_cmd_wr && !w_full;
    assign w_ovf_set = q_cmd_wr && w_full;
    assign w_pop     = (r_state == DONE) && !w_flush && !w_empty;
    // Interrupt only when this pop empties the queue and no new job lands in the same cycle.
    assign w_irq_set = w_pop && r_irq_en && (w_fill == FILL_W'(1)) && !w_push;

    blit_q_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (q_cmd_wr),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_din     (w_job),
        .o_head_c  (w_head),
        .o_fill    (w_fill),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    // Sequencer: load strobes and bus data are registered on entry to LDCNT/LDCMD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_countld   <= 1'b0;
            r_cmdld     <= 1'b0;
            r_blit_dout <= '0;
        end else begin
            r_countld   <= 1'b0;
            r_cmdld     <= 1'b0;
            r_blit_dout <= '0;
            case (r_state)
                IDLE: begin
                    if (!w_empty && !active && !stopped) begin
                        r_state     <= LDCNT;
                        r_countld   <= 1'b1;
                        r_blit_dout <= w_head.cnt;
                    end
                end
                LDCNT: begin
                    r_state     <= LDCMD;
                    r_cmdld     <= 1'b1;
                    r_blit_dout <= w_head.cmd;
                end
                LDCMD: r_state <= WSTART;
                WSTART: begin
                    if (active) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!active && !stopped) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // GPU-visible control/status registers; a set beats a same-cycle read clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage_cnt <= '0;
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (q_cnt_wr) begin
                r_stage_cnt <= gpu_din;
            end
            if (q_ctl_wr) begin
                r_irq_en <= gpu_din[CTL_IE];
            end
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (q_stat_rd) begin
                r_irq <= 1'b0;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (q_stat_rd) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_stat                    = '0;
        w_stat[STAT_OVF]          = r_ovf;
        w_stat[STAT_IRQ]          = r_irq;
        w_stat[STAT_BUSY]         = (r_state != IDLE);
        w_stat[STAT_IE]           = r_irq_en;
        w_stat[STAT_FILL_W-1:0]   = STAT_FILL_W'(w_fill);
    end

    assign blit_dout   = r_blit_dout;
    assign countld     = r_countld;
    assign cmdld       = r_cmdld;
    assign q_stat_dout = w_stat;
    assign q_stat_oe   = q_stat_rd;
    assign q_irq       = r_irq;
    assign q_full      = w_full;

endmodule

// File: tb/tb_blit_cmd_queue.sv
// Directed bench for blit_cmd_queue: job sequencing, overflow, stop hold,
// pointer wrap and asynchronous reset.
module tb_blit_cmd_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] gpu_din;
    logic        q_cnt_wr, q_cmd_wr, q_ctl_wr, q_stat_rd;
    logic        active, stopped;
    logic [31:0] blit_dout;
    logic        countld, cmdld;
    logic [15:0] q_stat_dout;
    logic        q_stat_oe, q_irq, q_full;

    int n_vec  = 0;
    int n_fail = 0;

    blit_cmd_queue #(.DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .gpu_din     (gpu_din),
        .q_cnt_wr    (q_cnt_wr),
        .q_cmd_wr    (q_cmd_wr),
        .q_ctl_wr    (q_ctl_wr),
        .q_stat_rd   (q_stat_rd),
        .active      (active),
        .stopped     (stopped),
        .blit_dout   (blit_dout),
        .countld     (countld),
        .cmdld       (cmdld),
        .q_stat_dout (q_stat_dout),
        .q_stat_oe   (q_stat_oe),
        .q_irq       (q_irq),
        .q_full      (q_full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_cnt(input logic [31:0] v);
        gpu_din = v; q_cnt_wr = 1'b1; step(); q_cnt_wr = 1'b0;
    endtask

    task automatic wr_cmd(input logic [31:0] v);
        gpu_din = v; q_cmd_wr = 1'b1; step(); q_cmd_wr = 1'b0;
    endtask

    task automatic wr_ctl(input logic [31:0] v);
        gpu_din = v; q_ctl_wr = 1'b1; step(); q_ctl_wr = 1'b0;
    endtask

    task automatic stat_rd();
        q_stat_rd = 1'b1; step(); q_stat_rd = 1'b0;
    endtask

    // Wait (bounded) for countld, check both loads, then walk the job through RUN/DONE back to IDLE.
    task automatic run_job(input string tag, input logic [31:0] ecnt, input logic [31:0] ecmd);
        int k;
        k = 0;
        while (!countld && k < 20) begin
            step();
            k++;
        end
        chk({tag, "_countld"}, 32'(countld), 32'd1);
        chk({tag, "_cnt"}, blit_dout, ecnt);
        step();
        chk({tag, "_cmdld"}, 32'({countld, cmdld}), 32'd1);
        chk({tag, "_cmd"}, blit_dout, ecmd);
        step();
        active = 1'b1;
        step();
        active = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset_n = 1'b0; gpu_din = '0;
        q_cnt_wr = 1'b0; q_cmd_wr = 1'b0; q_ctl_wr = 1'b0; q_stat_rd = 1'b0;
        active = 1'b0; stopped = 1'b0;
        step(); step();
        chk("rst_dout", blit_dout, 32'h0);
        chk("rst_lds", 32'({countld, cmdld}), 32'h0);
        chk("rst_stat", 32'(q_stat_dout), 32'h0);
        chk("rst_irq_full", 32'({q_irq, q_full, q_stat_oe}), 32'h0);
        reset_n = 1'b1;
        step();

        // Basic job with interrupt enabled
        wr_ctl(32'h1);
        wr_cnt(32'h0001_0010);
        wr_cmd(32'h0000_4001);
        chk("basic_idle_cycle", 32'(countld), 32'd0);
        step();
        chk("basic_countld", 32'(countld), 32'd1);
        chk("basic_cnt", blit_dout, 32'h0001_0010);
        step();
        chk("basic_cmdld", 32'({countld, cmdld}), 32'd1);
        chk("basic_cmd", blit_dout, 32'h0000_4001);
        step();
        chk("basic_wstart_dout", blit_dout, 32'h0);
        active = 1'b1;
        repeat (5) step();
        active = 1'b0;
        step();
        chk("basic_irq_early", 32'(q_irq), 32'd0);
        step();
        chk("basic_irq", 32'(q_irq), 32'd1);
        chk("basic_stat", 32'(q_stat_dout), 32'h5000);
        q_stat_rd = 1'b1;
        #1;
        chk("basic_oe", 32'(q_stat_oe), 32'd1);
        chk("basic_stat_preclr", 32'(q_stat_dout), 32'h5000);
        step();
        q_stat_rd = 1'b0;
        chk("basic_irq_clr", 32'(q_irq), 32'd0);

        // Fill to full, then overflow
        active = 1'b1;
        wr_cnt(32'h0000_000A);
        for (int i = 0; i < 5; i++) begin
            wr_cmd(32'h100 + 32'(i));
            if (i < 4) chk("ovf_full", 32'(q_full), 32'(i == 3));
        end
        chk("ovf_stat", 32'(q_stat_dout), 32'h9004);
        stat_rd();
        chk("ovf_stat_clr", 32'(q_stat_dout), 32'h1004);
        wr_ctl(32'h3);
        chk("flush_stat", 32'(q_stat_dout), 32'h1000);
        chk("flush_full", 32'(q_full), 32'd0);
        active = 1'b0;
        step();
        chk("flush_no_load", 32'(countld), 32'd0);

        // Three back-to-back jobs
        active = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wr_cnt(32'h20 + 32'(j));
            wr_cmd(32'hC0 + 32'(j));
        end
        chk("b2b_fill", 32'(q_stat_dout), 32'h1003);
        active = 1'b0;
        for (int j = 0; j < 3; j++) begin
            run_job("b2b", 32'h20 + 32'(j), 32'hC0 + 32'(j));
            chk("b2b_irq", 32'(q_irq), 32'(j == 2));
        end
        stat_rd();

        // Collision stop holds the sequencer in RUN
        wr_cnt(32'h33);
        wr_cmd(32'h44);
        step();
        chk("stop_cnt", blit_dout, 32'h33);
        step(); step();
        active = 1'b1;
        step();
        active = 1'b0;
        stopped = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                step();
                if (countld) seen++;
            end
            chk("stop_no_countld", 32'(seen), 32'd0);
        end
        chk("stop_hold_stat", 32'(q_stat_dout), 32'h3001);
        stopped = 1'b0;
        step(); step();
        chk("stop_released", 32'(q_stat_dout), 32'h5000);
        stat_rd();

        // Wrap: simultaneous cnt/cmd writes push the previous staged count
        wr_cnt(32'h500);
        for (int i = 0; i < 10; i++) begin
            gpu_din = 32'h501 + 32'(i);
            q_cnt_wr = 1'b1; q_cmd_wr = 1'b1;
            step();
            q_cnt_wr = 1'b0; q_cmd_wr = 1'b0;
            run_job("wrap", 32'h500 + 32'(i), 32'h501 + 32'(i));
        end
        chk("wrap_empty", 32'(q_stat_dout[4:0]), 32'd0);
        stat_rd();

        // Async reset mid-RUN with three jobs queued
        wr_cnt(32'h77);
        wr_cmd(32'h88);
        step(); step(); step();
        active = 1'b1;
        step();
        wr_cmd(32'h89);
        wr_cmd(32'h8A);
        chk("arst_pre", 32'(q_stat_dout), 32'h3003);
        reset_n = 1'b0;
        #1;
        chk("arst_stat", 32'(q_stat_dout), 32'h0);
        chk("arst_outs", 32'({countld, cmdld, q_irq, q_full}), 32'h0);
        chk("arst_dout", blit_dout, 32'h0);
        active = 1'b0;
        step();
        reset_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 5; k++) begin
                step();
                if (countld) seen++;
            end
            chk("arst_no_load", 32'(seen), 32'd0);
        end
        wr_cmd(32'h99);
        run_job("arst_new", 32'h0, 32'h99);
        chk("arst_irq_off", 32'(q_irq), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
